// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern constants, widths and types
package seg7_pkg;

  localparam int SEG_W      = 7;
  localparam int CODE_W     = 3;
  localparam int NUM_DIGITS = 1 << CODE_W;

  localparam logic [SEG_W-1:0] SEG7_BLANK = 7'b0000000;

  // Bit order gfedcba, 1 = lit
  localparam logic [SEG_W-1:0] SEG7_DIGIT [0:NUM_DIGITS-1] = '{
    7'b0111111,
    7'b0000110,
    7'b1011011,
    7'b1001111,
    7'b1100110,
    7'b1101101,
    7'b1111101,
    7'b0000111
  };

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seg7_state_t;

  typedef struct packed {
    logic [CODE_W-1:0]     code;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  none;
    logic                  err;
  } seg7_result_t;

endpackage

// File: rtl/seg7_readback_decoder_if.sv
// rtl/seg7_readback_decoder_if.sv - result handshake bundle of the readback decoder
interface seg7_readback_decoder_if;
  import seg7_pkg::*;

  logic                  out_valid;
  logic                  out_ready;
  logic [CODE_W-1:0]     out_code;
  logic [NUM_DIGITS-1:0] out_onehot;
  logic                  out_none;
  logic                  out_err;
  logic [7:0]            err_count;

  modport master (
    output out_valid, out_code, out_onehot, out_none, out_err, err_count,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_code, out_onehot, out_none, out_err, err_count,
    output out_ready
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to digit/none/error lookup
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  input  logic             dp,
  output seg7_result_t     result
);

  always_comb begin
    result = '0;
    if (dp) begin
      // A lit dp only means "none" when every segment is dark
      result.none = (seg == SEG7_BLANK);
      result.err  = (seg != SEG7_BLANK);
    end else begin
      result.err = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (seg == SEG7_DIGIT[i]) begin
          result.code   = CODE_W'(i);
          result.onehot = NUM_DIGITS'(1) << i;
          result.err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_readback_decoder.sv
// rtl/seg7_readback_decoder.sv - debounced seven-segment readback decoder; SEG7_ERR_COUNT_EN enables err_count
module seg7_readback_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic                    dp_in,
  seg7_readback_decoder_if.master rb
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [SEG_W:0] sample;
  logic [SEG_W:0] s_q;
  logic [SEG_W:0] emit_pat;
  logic [SEG_W:0] last_pat;
  logic           last_vld;
  logic [3:0]     cnt;
  seg7_state_t    state;
  seg7_state_t    state_nxt;
  seg7_result_t   dec;
  seg7_result_t   res_q;
  logic           launch;
  logic           handshake;

  assign sample = {dp_in, seg_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      cnt <= '0;
    end else begin
      s_q <= sample;
      if (sample == s_q) begin
        if (cnt != STABLE) cnt <= cnt + 4'd1;
      end else begin
        cnt <= '0;
      end
    end
  end

  seg7_pattern_decode u_decode (
    .seg    (s_q[SEG_W-1:0]),
    .dp     (s_q[SEG_W]),
    .result (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (cnt == STABLE && (!last_vld || s_q != last_pat)) begin
          launch    = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (rb.out_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result is frozen at launch so a changing input cannot disturb a pending transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      emit_pat <= '0;
      last_pat <= '0;
      last_vld <= 1'b0;
    end else if (launch) begin
      res_q    <= dec;
      emit_pat <= s_q;
    end else if (handshake) begin
      res_q    <= '0;
      last_pat <= emit_pat;
      last_vld <= 1'b1;
    end
  end

  always_comb begin
    rb.out_valid  = 1'b0;
    rb.out_code   = '0;
    rb.out_onehot = '0;
    rb.out_none   = 1'b0;
    rb.out_err    = 1'b0;
    if (state == EMIT) begin
      rb.out_valid  = 1'b1;
      rb.out_code   = res_q.code;
      rb.out_onehot = res_q.onehot;
      rb.out_none   = res_q.none;
      rb.out_err    = res_q.err;
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (handshake && res_q.err && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign rb.err_count = err_cnt_q;
`else
  assign rb.err_count = '0;
`endif

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// tb/tb_seg7_readback_decoder.sv - directed self-checking bench for seg7_readback_decoder
module tb_seg7_readback_decoder;

`ifdef SEG7_ERR_COUNT_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       dp_in;

  int checks = 0;
  int errors = 0;

  int         ntx;
  int         first_k;
  logic [2:0] cap_code;
  logic [7:0] cap_onehot;
  logic       cap_none;
  logic       cap_err;
  logic [7:0] cap_ec;

  seg7_readback_decoder_if rb_if ();

  seg7_readback_decoder #(.STABLE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_in (seg_in),
    .dp_in  (dp_in),
    .rb     (rb_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs n edges; records the first edge index with out_valid and its payload
  task automatic run(input int n);
    ntx     = 0;
    first_k = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rb_if.out_valid) begin
        if (first_k < 0) begin
          first_k    = k;
          cap_code   = rb_if.out_code;
          cap_onehot = rb_if.out_onehot;
          cap_none   = rb_if.out_none;
          cap_err    = rb_if.out_err;
          cap_ec     = rb_if.err_count;
        end
        if (rb_if.out_ready) ntx++;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    rb_if.out_ready = 1'b1;
    seg_in          = 7'b1101101;
    dp_in           = 1'b0;
    #2;
    check("rst_valid",  32'(rb_if.out_valid),  32'd0);
    check("rst_code",   32'(rb_if.out_code),   32'd0);
    check("rst_onehot", 32'(rb_if.out_onehot), 32'd0);
    check("rst_errcnt", 32'(rb_if.err_count),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Digit 5 held 12 cycles
    run(12);
    check("d5_latency", 32'(first_k),    32'd5);
    check("d5_ntx",     32'(ntx),        32'd1);
    check("d5_code",    32'(cap_code),   32'd5);
    check("d5_onehot",  32'(cap_onehot), 32'h20);
    check("d5_none",    32'(cap_none),   32'd0);
    check("d5_err",     32'(cap_err),    32'd0);

    // Short digit 3 followed by digit 7
    seg_in = 7'b1001111;
    run(3);
    check("d3_ntx", 32'(ntx), 32'd0);
    seg_in = 7'b0000111;
    run(10);
    check("d7_latency", 32'(first_k),    32'd5);
    check("d7_ntx",     32'(ntx),        32'd1);
    check("d7_code",    32'(cap_code),   32'd7);
    check("d7_onehot",  32'(cap_onehot), 32'h80);

    // Blank with dp lit
    seg_in = 7'b0000000;
    dp_in  = 1'b1;
    run(6);
    check("none_latency", 32'(first_k),    32'd5);
    check("none_none",    32'(cap_none),   32'd1);
    check("none_code",    32'(cap_code),   32'd0);
    check("none_onehot",  32'(cap_onehot), 32'd0);
    check("none_err",     32'(cap_err),    32'd0);

    // Illegal pattern, all segments lit
    seg_in = 7'b1111111;
    dp_in  = 1'b0;
    run(7);
    check("err_latency", 32'(first_k),         32'd5);
    check("err_err",     32'(cap_err),         32'd1);
    check("err_code",    32'(cap_code),        32'd0);
    check("err_pre_cnt", 32'(cap_ec),          32'd0);
    check("err_count",   32'(rb_if.err_count), 32'(EXP_ERR));

    // Backpressure: digit 2 pending while input moves to digit 6
    rb_if.out_ready = 1'b0;
    seg_in          = 7'b1011011;
    run(8);
    check("bp_latency", 32'(first_k),  32'd5);
    check("bp_code2",   32'(cap_code), 32'd2);
    check("bp_ntx",     32'(ntx),      32'd0);
    seg_in = 7'b1111101;
    run(12);
    check("bp_hold_valid",  32'(rb_if.out_valid),  32'd1);
    check("bp_hold_code",   32'(rb_if.out_code),   32'd2);
    check("bp_hold_onehot", 32'(rb_if.out_onehot), 32'h04);
    rb_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_hs_valid", 32'(rb_if.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_d6_valid",  32'(rb_if.out_valid),  32'd1);
    check("bp_d6_code",   32'(rb_if.out_code),   32'd6);
    check("bp_d6_onehot", 32'(rb_if.out_onehot), 32'h40);
    @(posedge clk);
    #1;
    check("bp_d6_done", 32'(rb_if.out_valid), 32'd0);

    // Reset during EMIT, then same pattern re-emitted
    seg_in = 7'b1100110;
    run(6);
    check("rst_mid_pre", 32'(rb_if.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid",  32'(rb_if.out_valid), 32'd0);
    check("rst_mid_code",   32'(rb_if.out_code),  32'd0);
    check("rst_mid_errcnt", 32'(rb_if.err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(8);
    check("rst_re_latency", 32'(first_k),    32'd5);
    check("rst_re_code",    32'(cap_code),   32'd4);
    check("rst_re_onehot",  32'(cap_onehot), 32'h10);
    check("rst_re_ntx",     32'(ntx),        32'd1);

    // Digit 0 held exactly STABLE_CYCLES samples is dropped
    seg_in = 7'b0111111;
    run(4);
    check("short_ntx", 32'(ntx), 32'd0);
    seg_in = 7'b0000110;
    run(8);
    check("d1_latency", 32'(first_k),    32'd5);
    check("d1_code",    32'(cap_code),   32'd1);
    check("d1_onehot",  32'(cap_onehot), 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
